dcache_wbuf: RTL and testbench

Parametrised data-cache write buffer; successor to the single-mode dcache write FIFO. It sits between the dcache and the AXI write master and queues dirty or evicted lines with per-byte strobes. It merges stores into buffered lines at byte granularity and forwards the youngest buffered bytes to dcache reads. It drains through a valid/ready plus write-response handshake and supports an explicit flush.

---
 rtl/dcache_wbuf_pkg.sv | 21 ++
 rtl/dcache_wbuf_fwd_merge.sv | 46 ++++
 rtl/dcache_wbuf.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_wbuf.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wbuf_pkg.sv
// rtl/dcache_wbuf_pkg.sv - shared types and defaults for the dcache write buffer
package dcache_wbuf_pkg;

   localparam int DCACHE_WBUF_DEPTH  = 4;
   localparam int DCACHE_WBUF_LINE_W = 128;
   localparam int DCACHE_WBUF_ADDR_W = 32;

   // One buffered line as seen by external users of the buffer
   typedef struct packed {
      logic [DCACHE_WBUF_ADDR_W-1:0]   addr;
      logic [DCACHE_WBUF_LINE_W-1:0]   data;
      logic [DCACHE_WBUF_LINE_W/8-1:0] strb;
   } wbuf_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT_B = 2'd2
   } wbuf_state_t;

endpackage

// File: rtl/dcache_wbuf_fwd_merge.sv
// rtl/dcache_wbuf_fwd_merge.sv - per-byte youngest-match selector over the buffer ring
module wbuf_fwd_merge #(
   parameter int DEPTH      = 4,
   parameter int LINE_WIDTH = 128,
   parameter int TAG_W      = 28,
   parameter int PTR_W      = 2
) (
   input  logic [DEPTH-1:0][TAG_W-1:0]        tag_i,
   input  logic [DEPTH-1:0][LINE_WIDTH-1:0]   data_i,
   input  logic [DEPTH-1:0][LINE_WIDTH/8-1:0] strb_i,
   input  logic [DEPTH-1:0]                   valid_i,
   input  logic [PTR_W-1:0]                   head_i,
   input  logic [PTR_W-1:0]                   tail_i,
   input  logic [TAG_W-1:0]                   lookup_tag_i,
   output logic [LINE_WIDTH-1:0]              data_o,
   output logic [LINE_WIDTH/8-1:0]            mask_o
);

   localparam int NB = LINE_WIDTH / 8;

   logic [PTR_W-1:0] idx;
   logic             past;

   // Walk from the youngest slot (tail-1) back to the head; first byte claimed wins
   always_comb begin
      data_o = '0;
      mask_o = '0;
      past   = 1'b0;
      idx    = tail_i;
      for (int k = 1; k <= DEPTH; k++) begin
         idx = tail_i - PTR_W'(k);
         if (!past && valid_i[idx] && (tag_i[idx] == lookup_tag_i)) begin
            for (int b = 0; b < NB; b++) begin
               if (strb_i[idx][b] && !mask_o[b]) begin
                  mask_o[b]        = 1'b1;
                  data_o[b*8 +: 8] = data_i[idx][b*8 +: 8];
               end
            end
         end
         if (idx == head_i) begin
            past = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcache_wbuf.sv
// rtl/dcache_wbuf.sv - dcache write buffer with merge, forwarding and AXI drain; DCACHE_WBUF_STAT_EN adds counters
module dcache_wbuf
   import dcache_wbuf_pkg::*;
#(
   parameter int DEPTH      = DCACHE_WBUF_DEPTH,
   parameter int LINE_WIDTH = DCACHE_WBUF_LINE_W,
   parameter int ADDR_WIDTH = DCACHE_WBUF_ADDR_W,
   parameter int OFFSET_W   = $clog2(LINE_WIDTH/8)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_wreq_i,
   input  logic [ADDR_WIDTH-1:0]     cpu_awaddr_i,
   input  logic [LINE_WIDTH-1:0]     cpu_wdata_i,
   input  logic [LINE_WIDTH/8-1:0]   cpu_wstrb_i,
   output logic                      cpu_wready_o,
   output logic                      write_hit_o,
   input  logic                      cpu_rreq_i,
   input  logic [ADDR_WIDTH-1:0]     cpu_araddr_i,
   output logic                      read_hit_o,
   output logic [LINE_WIDTH-1:0]     cpu_rdata_o,
   output logic [LINE_WIDTH/8-1:0]   cpu_rmask_o,
   input  logic                      flush_i,
   output logic                      flush_done_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      axi_wvalid_o,
   input  logic                      axi_wready_i,
   output logic [ADDR_WIDTH-1:0]     axi_awaddr_o,
   output logic [LINE_WIDTH-1:0]     axi_wdata_o,
   output logic [LINE_WIDTH/8-1:0]   axi_wstrb_o,
   input  logic                      axi_bvalid_i
`ifdef DCACHE_WBUF_STAT_EN
  ,output logic [31:0]               merge_cnt_o,
   output logic [31:0]               stall_cnt_o
`endif
);

   localparam int NB    = LINE_WIDTH / 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam int TAG_W = ADDR_WIDTH - OFFSET_W;

   logic [DEPTH-1:0][TAG_W-1:0]      tag_q;
   logic [DEPTH-1:0][LINE_WIDTH-1:0] data_q;
   logic [DEPTH-1:0][NB-1:0]         strb_q;
   logic [DEPTH-1:0]                 valid_q, valid_d;
   logic [PTR_W-1:0]                 head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]                    count_q, count_d;
   wbuf_state_t                      state_q, state_d;

   logic                  write_hit_q, read_hit_q;
   logic [LINE_WIDTH-1:0] rdata_q;
   logic [NB-1:0]         rmask_q;

   logic [TAG_W-1:0]      wtag, rtag;
   logic [DEPTH-1:0]      hit_vec;
   logic [PTR_W-1:0]      hit_idx;
   logic                  hit_any, full, empty, do_merge, do_alloc, pop;
   logic [LINE_WIDTH-1:0] fwd_data;
   logic [NB-1:0]         fwd_mask;
   logic                  unused_offsets;

   // Offsets never take part in tag compares; the drain address is line aligned
   assign unused_offsets = ^{cpu_awaddr_i[OFFSET_W-1:0], cpu_araddr_i[OFFSET_W-1:0]};
   assign wtag  = cpu_awaddr_i[ADDR_WIDTH-1:OFFSET_W];
   assign rtag  = cpu_araddr_i[ADDR_WIDTH-1:OFFSET_W];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Find the single unlocked entry that a store may merge into
   always_comb begin
      hit_vec = '0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (tag_q[i] == wtag) &&
             !((state_q != IDLE) && (PTR_W'(i) == head_q))) begin
            hit_vec[i] = 1'b1;
            hit_idx    = PTR_W'(i);
         end
      end
   end

   assign hit_any      = |hit_vec;
   assign do_merge     = cpu_wreq_i & hit_any;
   assign do_alloc     = cpu_wreq_i & ~hit_any & ~full & ~flush_i;
   assign cpu_wready_o = do_merge | do_alloc;

   // Drain FSM next state; the head pops when its write response arrives
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE:    if (!empty) state_d = SEND;
         SEND:    if (axi_wready_i) state_d = WAIT_B;
         WAIT_B:  if (axi_bvalid_i) begin
                     state_d = IDLE;
                     pop     = 1'b1;
                  end
         default: state_d = IDLE;
      endcase
   end

   // Ring pointer, valid and occupancy bookkeeping
   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (do_alloc) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      count_d = count_q + CW'(do_alloc) - CW'(pop);
   end

   wbuf_fwd_merge #(
      .DEPTH      (DEPTH),
      .LINE_WIDTH (LINE_WIDTH),
      .TAG_W      (TAG_W),
      .PTR_W      (PTR_W)
   ) u_fwd (
      .tag_i        (tag_q),
      .data_i       (data_q),
      .strb_i       (strb_q),
      .valid_i      (valid_q),
      .head_i       (head_q),
      .tail_i       (tail_q),
      .lookup_tag_i (rtag),
      .data_o       (fwd_data),
      .mask_o       (fwd_mask)
   );

   // Control state and registered responses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         valid_q     <= '0;
         write_hit_q <= 1'b0;
         read_hit_q  <= 1'b0;
         rdata_q     <= '0;
         rmask_q     <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         if (cpu_wready_o) begin
            write_hit_q <= do_merge;
         end
         if (cpu_rreq_i) begin
            read_hit_q <= |fwd_mask;
            rdata_q    <= fwd_data;
            rmask_q    <= fwd_mask;
         end
      end
   end

   // Entry payload: allocation loads the tail, merges patch strobed bytes
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         tag_q[tail_q]  <= wtag;
         data_q[tail_q] <= cpu_wdata_i;
         strb_q[tail_q] <= cpu_wstrb_i;
      end else if (do_merge) begin
         for (int b = 0; b < NB; b++) begin
            if (cpu_wstrb_i[b]) begin
               data_q[hit_idx][b*8 +: 8] <= cpu_wdata_i[b*8 +: 8];
            end
         end
         strb_q[hit_idx] <= strb_q[hit_idx] | cpu_wstrb_i;
      end
   end

   assign write_hit_o  = write_hit_q;
   assign read_hit_o   = read_hit_q;
   assign cpu_rdata_o  = rdata_q;
   assign cpu_rmask_o  = rmask_q;
   assign count_o      = count_q;
   assign flush_done_o = empty & (state_q == IDLE);
   assign axi_wvalid_o = (state_q == SEND);
   assign axi_awaddr_o = {tag_q[head_q], {OFFSET_W{1'b0}}};
   assign axi_wdata_o  = data_q[head_q];
   assign axi_wstrb_o  = strb_q[head_q];

`ifdef DCACHE_WBUF_STAT_EN
   logic [31:0] merge_cnt_q, stall_cnt_q;

   // Saturating merge and write-stall counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         merge_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (do_merge && (merge_cnt_q != 32'hFFFF_FFFF)) begin
            merge_cnt_q <= merge_cnt_q + 32'd1;
         end
         if (cpu_wreq_i && !cpu_wready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign merge_cnt_o = merge_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wbuf.sv
// tb/tb_dcache_wbuf.sv - directed and random checks of dcache_wbuf against a queue model
module tb_dcache_wbuf;

   localparam int DEPTH = 4;
   localparam int LW    = 128;
   localparam int AW    = 32;
   localparam int NB    = LW / 8;
   localparam int TW    = AW - 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_wreq_i, cpu_rreq_i, flush_i, axi_wready_i, axi_bvalid_i;
   logic [AW-1:0] cpu_awaddr_i, cpu_araddr_i;
   logic [LW-1:0] cpu_wdata_i;
   logic [NB-1:0] cpu_wstrb_i;
   logic          cpu_wready_o, write_hit_o, read_hit_o, flush_done_o, axi_wvalid_o;
   logic [LW-1:0] cpu_rdata_o, axi_wdata_o;
   logic [NB-1:0] cpu_rmask_o, axi_wstrb_o;
   logic [AW-1:0] axi_awaddr_o;
   logic [2:0]    count_o;
`ifdef DCACHE_WBUF_STAT_EN
   logic [31:0]   merge_cnt_o, stall_cnt_o;
`endif

   always #5 clk = ~clk;

   dcache_wbuf dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_wreq_i   (cpu_wreq_i),
      .cpu_awaddr_i (cpu_awaddr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_wstrb_i  (cpu_wstrb_i),
      .cpu_wready_o (cpu_wready_o),
      .write_hit_o  (write_hit_o),
      .cpu_rreq_i   (cpu_rreq_i),
      .cpu_araddr_i (cpu_araddr_i),
      .read_hit_o   (read_hit_o),
      .cpu_rdata_o  (cpu_rdata_o),
      .cpu_rmask_o  (cpu_rmask_o),
      .flush_i      (flush_i),
      .flush_done_o (flush_done_o),
      .count_o      (count_o),
      .axi_wvalid_o (axi_wvalid_o),
      .axi_wready_i (axi_wready_i),
      .axi_awaddr_o (axi_awaddr_o),
      .axi_wdata_o  (axi_wdata_o),
      .axi_wstrb_o  (axi_wstrb_o),
      .axi_bvalid_i (axi_bvalid_i)
`ifdef DCACHE_WBUF_STAT_EN
     ,.merge_cnt_o  (merge_cnt_o),
      .stall_cnt_o  (stall_cnt_o)
`endif
   );

   typedef struct {
      logic [TW-1:0] tag;
      logic [LW-1:0] data;
      logic [NB-1:0] strb;
   } ment_t;

   ment_t         mq[$];
   int            m_phase;
   logic          m_whit, m_rhit;
   logic [LW-1:0] m_rdata;
   logic [NB-1:0] m_rmask;
   logic          obs_wready;
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] bmask(input logic [NB-1:0] s);
      logic [LW-1:0] m = '0;
      for (int b = 0; b < NB; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic mreset();
      mq.delete();
      m_phase = 0;
      m_whit  = 1'b0;
      m_rhit  = 1'b0;
      m_rdata = '0;
      m_rmask = '0;
   endtask

   // One clock: drive at negedge, check combinational outputs, advance model, check registers
   task automatic cyc(input logic wreq, input logic [AW-1:0] wa, input logic [LW-1:0] wd,
                      input logic [NB-1:0] ws, input logic rreq, input logic [AW-1:0] ra,
                      input logic fl, input logic wr, input logic bv);
      int            hit_i;
      logic          e_merge, e_alloc;
      logic [LW-1:0] e_rdata, bm;
      logic [NB-1:0] e_rmask;
      ment_t         t;
      cpu_wreq_i = wreq; cpu_awaddr_i = wa; cpu_wdata_i = wd; cpu_wstrb_i = ws;
      cpu_rreq_i = rreq; cpu_araddr_i = ra; flush_i = fl;
      axi_wready_i = wr; axi_bvalid_i = bv;
      #1;
      hit_i = -1;
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].tag == wa[AW-1:4] && !(i == 0 && m_phase != 0)) hit_i = i;
      e_merge = wreq && (hit_i >= 0);
      e_alloc = wreq && (hit_i < 0) && (mq.size() < DEPTH) && !fl;
      chk("cpu_wready", 128'(cpu_wready_o), 128'(e_merge | e_alloc));
      chk("count", 128'(count_o), 128'(mq.size()));
      chk("flush_done", 128'(flush_done_o), 128'(mq.size() == 0 && m_phase == 0));
      chk("axi_wvalid", 128'(axi_wvalid_o), 128'(m_phase == 1));
      if (m_phase == 1) begin
         bm = bmask(mq[0].strb);
         chk("axi_awaddr", 128'(axi_awaddr_o), 128'({mq[0].tag, 4'h0}));
         chk("axi_wstrb", 128'(axi_wstrb_o), 128'(mq[0].strb));
         chk("axi_wdata", axi_wdata_o & bm, mq[0].data & bm);
      end
      obs_wready = cpu_wready_o;
      e_rdata = '0;
      e_rmask = '0;
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].tag == ra[AW-1:4])
            for (int b = 0; b < NB; b++)
               if (mq[i].strb[b]) begin
                  e_rmask[b] = 1'b1;
                  e_rdata[b*8 +: 8] = mq[i].data[b*8 +: 8];
               end
      if (rreq) begin
         m_rhit  = |e_rmask;
         m_rdata = e_rdata;
         m_rmask = e_rmask;
      end
      if (e_merge || e_alloc) m_whit = e_merge;
      if (e_merge) begin
         t = mq[hit_i];
         for (int b = 0; b < NB; b++) if (ws[b]) t.data[b*8 +: 8] = wd[b*8 +: 8];
         t.strb = t.strb | ws;
         mq[hit_i] = t;
      end
      case (m_phase)
         0: if (mq.size() != 0) m_phase = 1;
         1: if (wr) m_phase = 2;
         default: if (bv) begin m_phase = 0; void'(mq.pop_front()); end
      endcase
      if (e_alloc) begin
         t.tag = wa[AW-1:4]; t.data = wd; t.strb = ws;
         mq.push_back(t);
      end
      @(posedge clk);
      #1;
      chk("write_hit", 128'(write_hit_o), 128'(m_whit));
      chk("read_hit", 128'(read_hit_o), 128'(m_rhit));
      chk("rmask", 128'(cpu_rmask_o), 128'(m_rmask));
      chk("rdata", cpu_rdata_o, m_rdata);
      @(negedge clk);
   endtask

   task automatic wr_line(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [NB-1:0] s,
                          input logic wr, input logic bv);
      cyc(1'b1, a, d, s, 1'b0, '0, 1'b0, wr, bv);
   endtask

   task automatic idle(input logic rreq, input logic [AW-1:0] ra, input logic fl,
                       input logic wr, input logic bv);
      cyc(1'b0, '0, '0, '0, rreq, ra, fl, wr, bv);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && !flush_done_o; i++) idle(1'b0, '0, 1'b1, 1'b1, 1'b1);
      chk("drain_done", 128'(flush_done_o), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, pops, prev;
      logic [TW-1:0] tg;
      mreset();
      rst = 1'b0;
      cpu_wreq_i = 0; cpu_awaddr_i = '0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
      cpu_rreq_i = 0; cpu_araddr_i = '0; flush_i = 0; axi_wready_i = 0; axi_bvalid_i = 0;
      @(negedge clk);
      #1;
      chk("rst_count", 128'(count_o), 128'(0));
      chk("rst_flush_done", 128'(flush_done_o), 128'(1));
      chk("rst_wvalid", 128'(axi_wvalid_o), 128'(0));
      chk("rst_read_hit", 128'({read_hit_o, write_hit_o, cpu_rmask_o}), 128'(0));
      @(negedge clk);
      rst = 1'b1;

      // Allocate then merge before the head locks; lookup in the same cycle sees only the first write
      wr_line(32'h1000, {96'h0, 32'h11223344}, 16'h000F, 1'b0, 1'b0);
      cyc(1'b1, 32'h1000, {32'hA5A5A5A5, 96'h0}, 16'hF000, 1'b1, 32'h1008, 1'b0, 1'b0, 1'b0);
      chk("t1_read_hit", 128'(read_hit_o), 128'(1));
      chk("t1_rmask", 128'(cpu_rmask_o), 128'(16'h000F));
      chk("t1_rdata", 128'(cpu_rdata_o[31:0]), 128'(32'h11223344));
      chk("t2_write_hit", 128'(write_hit_o), 128'(1));
      chk("t2_count", 128'(count_o), 128'(1));
      chk("t2_wvalid", 128'(axi_wvalid_o), 128'(1));
      chk("t2_wstrb", 128'(axi_wstrb_o), 128'(16'hF00F));
      chk("t2_awaddr", 128'(axi_awaddr_o), 128'(32'h1000));
      idle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t2_popped", 128'(count_o), 128'(0));

      // Fill to full, stall, then a pop frees space only from the next cycle
      for (int i = 0; i < 4; i++)
         wr_line(32'h2000 + 32'(i) * 32'h1000, {4{$urandom}}, 16'hFFFF, 1'b0, 1'b0);
      chk("t3_full", 128'(count_o), 128'(4));
      wr_line(32'h6000, '1, 16'h00FF, 1'b1, 1'b0);
      chk("t3_stall_full", 128'(obs_wready), 128'(0));
      wr_line(32'h6000, '1, 16'h00FF, 1'b0, 1'b1);
      chk("t3_stall_nobypass", 128'(obs_wready), 128'(0));
      chk("t3_after_pop", 128'(count_o), 128'(3));
      wr_line(32'h6000, '1, 16'h00FF, 1'b0, 1'b0);
      chk("t3_accept", 128'(obs_wready), 128'(1));
      chk("t3_refull", 128'(count_o), 128'(4));
      drain();

      // Store to the locked head allocates a fresh entry; forwarding combines both
      wr_line(32'h7000, {96'h0, 32'hDEADBEEF}, 16'h000F, 1'b0, 1'b0);
      idle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      wr_line(32'h7004, {64'h0, 32'hCAFEF00D, 32'h0}, 16'h00F0, 1'b0, 1'b0);
      chk("t4_write_hit", 128'(write_hit_o), 128'(0));
      chk("t4_count", 128'(count_o), 128'(2));
      idle(1'b1, 32'h7000, 1'b0, 1'b0, 1'b0);
      chk("t4_rmask", 128'(cpu_rmask_o), 128'(16'h00FF));
      chk("t4_rdata", 128'(cpu_rdata_o[63:0]), 128'(64'hCAFEF00D_DEADBEEF));
      drain();

      // Flush with three entries: new lines stall, all three drain
      for (int i = 0; i < 3; i++)
         wr_line(32'h8000 + 32'(i) * 32'h1000, {4{$urandom}}, 16'h0F0F, 1'b0, 1'b0);
      acc = 0; pops = 0; prev = 3;
      for (int i = 0; i < 40 && !flush_done_o; i++) begin
         cyc(1'b1, 32'hB000, '0, 16'hFFFF, 1'b0, '0, 1'b1, 1'b1, 1'b1);
         if (obs_wready) acc++;
         if (int'(count_o) < prev) pops += prev - int'(count_o);
         prev = int'(count_o);
      end
      chk("t5_no_accept", 128'(acc), 128'(0));
      chk("t5_pops", 128'(pops), 128'(3));
      chk("t5_done", 128'(flush_done_o), 128'(1));

      // Asynchronous reset while waiting for a write response
      wr_line(32'hC000, '1, 16'hFFFF, 1'b0, 1'b0);
      idle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("t6_count", 128'(count_o), 128'(0));
      chk("t6_wvalid", 128'(axi_wvalid_o), 128'(0));
      chk("t6_flush_done", 128'(flush_done_o), 128'(1));
      mreset();
      @(negedge clk);
      rst = 1'b1;

      // Random traffic over a small pool of lines
      flush_i = 1'b0;
      for (int n = 0; n < 600; n++) begin
         logic fl;
         fl = (n % 100) > 85;
         tg = TW'(28'h100 + $urandom_range(0, 5));
         cyc($urandom_range(0, 3) != 0, {tg, 4'($urandom)}, {4{$urandom}}, 16'($urandom),
             $urandom_range(0, 1) == 1, {TW'(28'h100 + $urandom_range(0, 5)), 4'($urandom)},
             fl, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
